dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words in the internal data array (power of two).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 1, meaning the wait states inserted between request capture and response (0..15).
REQ-003 Port `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port `reset`, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port `req`, input, 1 bit: access request from the CPU, held high until `MIO_ready` is seen.
REQ-006 Port `mem_w`, input, 1 bit: 1 = write access, 0 = read access.
REQ-007 Port `Addr_in`, input, 32 bits: byte address.
REQ-008 Port `Data_in`, input, 32 bits: write data, already lane-aligned by the initiator.
REQ-009 Port `dm_ctrl`, input, 3 bits: access size (word, halfword, halfword unsigned, byte, byte unsigned).
REQ-010 Port `Data_out`, output, 32 bits: full aligned read word; the initiator performs extraction and extension.
REQ-011 Port `MIO_ready`, output, 1 bit: one-cycle response strobe.
REQ-012 Port `err`, output, 1 bit: one-cycle misalignment strobe, coincident with `MIO_ready`.

Function
REQ-013 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-014 In IDLE with `req`=1, the block SHALL capture `mem_w`, `Addr_in`, `Data_in` and `dm_ctrl`, then go to WAIT, or directly to RESP if WAIT_CYCLES=0.
REQ-015 WAIT SHALL count WAIT_CYCLES cycles, then go to RESP; RESP SHALL always return to IDLE after one cycle.
REQ-016 `MIO_ready` SHALL be 1 only in RESP, giving a latency of WAIT_CYCLES+1 cycles from the capture edge.
REQ-017 Input changes after capture, including `req` dropping mid-WAIT, SHALL NOT affect the transaction; it SHALL complete.
REQ-018 A new request SHALL be accepted no earlier than the IDLE cycle following RESP; back-to-back accesses therefore take WAIT_CYCLES+2 cycles each.
REQ-019 The word index SHALL be the captured Addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap.
REQ-020 The lane mask SHALL be:
- word: 1111
- halfword: 0011 if addr[1]=0, else 1100
- byte: 0001 shifted left by addr[1:0]
REQ-021 A write SHALL update only the masked bytes, on the edge entering RESP.
REQ-022 A read SHALL register the whole word into `Data_out` on the edge entering RESP.
REQ-023 `Data_out` SHALL hold its value until the next read completes; write responses leave it unchanged.
REQ-024 Array contents after power-up SHALL be undefined, and the bench SHALL NOT rely on them.

Reset
REQ-025 `reset` SHALL force the state to IDLE, the wait counter to 0, `MIO_ready` to 0, `err` to 0 and `Data_out` to 0.
REQ-026 Assertion of `reset` mid-transaction SHALL abort the transaction: no array write and no response.
REQ-027 `reset` SHALL NOT clear the data array.

Configuration
REQ-028 With DMEM_MISALIGN_CHECK_EN defined, a misaligned access SHALL pulse `err`=1 with `MIO_ready`, suppress any array write, and leave `Data_out` unchanged.
- Misaligned means: a word access with addr[1:0]!=0, or a halfword access with addr[0]=1.
REQ-029 Without DMEM_MISALIGN_CHECK_EN, `err` SHALL be tied to 0 and misaligned accesses SHALL use the REQ-020 mask, ignoring the offending low bits.

Structure
REQ-030 The shared package dmem_pkg SHALL hold the dm_ctrl encodings (word 000, half 001, half-unsigned 010, byte 011, byte-unsigned 100), the FSM state typedef, and the mask constants.
REQ-031 Lane-mask generation SHALL be a combinational sub-module, dmem_lane_decode (dm_ctrl + addr[1:0] -> 4-bit mask).
REQ-032 The array, FSM and counter SHALL reside in dmem_responder.

Verification
REQ-033 Word write then read: write 0xDEADBEEF to 0x10 with WAIT_CYCLES=1, then read 0x10 -> `MIO_ready` arrives 2 cycles after each capture and `Data_out`=0xDEADBEEF.
REQ-034 Byte write: after word 0x00000000 at 0x20, byte write with Data_in=0x0000AB00 to 0x21, then read -> 0x0000AB00.
REQ-035 Halfword write: half write with Data_in=0x12340000 to 0x22 over 0xFFFFFFFF -> read returns 0x1234FFFF.
REQ-036 Wrap and hold: with DEPTH_WORDS=1024, write to 0x1004 then read 0x0004 -> same data; a following write response leaves `Data_out` unchanged.
REQ-037 Abort: assert `reset` during WAIT of a write to 0x30 -> `MIO_ready` never pulses and a subsequent read of 0x30 returns the prior value.
REQ-038 Misalignment, macro defined: word write to 0x31 -> `err`=1 and `MIO_ready`=1 in the same cycle, memory unchanged; macro undefined -> `err` stays 0 and the write lands at word 0x30.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access-size encodings, FSM states,
// lane-mask constants and the alignment helper.
package dmem_pkg;

    localparam logic [2:0] DmWord  = 3'b000;
    localparam logic [2:0] DmHalf  = 3'b001;
    localparam logic [2:0] DmHalfU = 3'b010;
    localparam logic [2:0] DmByte  = 3'b011;
    localparam logic [2:0] DmByteU = 3'b100;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    localparam logic [3:0] MaskWord   = 4'b1111;
    localparam logic [3:0] MaskHalfLo = 4'b0011;
    localparam logic [3:0] MaskHalfHi = 4'b1100;
    localparam logic [3:0] MaskByte0  = 4'b0001;
    localparam logic [3:0] MaskNone   = 4'b0000;

    function automatic logic misaligned(input logic [2:0] ctrl, input logic [1:0] addr_lo);
        logic res;
        res = 1'b0;
        if (ctrl == DmWord) begin
            res = (addr_lo != 2'b00);
        end else if (ctrl == DmHalf || ctrl == DmHalfU) begin
            res = addr_lo[0];
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_lane_decode.sv
// Combinational byte-lane mask from access size and the low two address bits.
module dmem_lane_decode
    import dmem_pkg::*;
(
    input  logic [2:0] dm_ctrl_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] mask_o
);

    always_comb begin
        mask_o = MaskNone;
        case (dm_ctrl_i)
            DmWord:          mask_o = MaskWord;
            DmHalf, DmHalfU: mask_o = addr_lo_i[1] ? MaskHalfHi : MaskHalfLo;
            DmByte, DmByteU: mask_o = MaskByte0 << addr_lo_i;
            default:         mask_o = MaskNone;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data memory responder: IDLE/WAIT/RESP handshake over a word array.
// Optional misalignment trapping when DMEM_MISALIGN_CHECK_EN is defined.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        mem_w,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_in,
    input  logic [2:0]  dm_ctrl,
    output logic [31:0] Data_out,
    output logic        MIO_ready,
    output logic        err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LastCnt = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [31:0] mem [DEPTH_WORDS];

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        wr_q;
    logic [AW+1:0] addr_q;
    logic [31:0] data_q;
    logic [2:0]  ctrl_q;
    logic [31:0] rdata_q;
    logic        ready_q;
    logic        err_q;

    logic        cur_wr;
    logic [AW+1:0] cur_addr;
    logic [31:0] cur_data;
    logic [2:0]  cur_ctrl;
    logic [3:0]  cur_mask;
    logic        cur_bad;
    logic        go_resp;
    logic        mem_we;
    logic [AW-1:0] cur_idx;

    logic unused_addr;
    assign unused_addr = ^Addr_in[31:AW+2];

    // Entering RESP straight from IDLE (no wait states) must act on the live inputs.
    always_comb begin
        cur_wr   = wr_q;
        cur_addr = addr_q;
        cur_data = data_q;
        cur_ctrl = ctrl_q;
        if (state_q == StIdle) begin
            cur_wr   = mem_w;
            cur_addr = Addr_in[AW+1:0];
            cur_data = Data_in;
            cur_ctrl = dm_ctrl;
        end
    end

    assign cur_idx = cur_addr[AW+1:2];

    dmem_lane_decode u_lane_decode (
        .dm_ctrl_i (cur_ctrl),
        .addr_lo_i (cur_addr[1:0]),
        .mask_o    (cur_mask)
    );

`ifdef DMEM_MISALIGN_CHECK_EN
    assign cur_bad = misaligned(cur_ctrl, cur_addr[1:0]);
`else
    assign cur_bad = 1'b0;
`endif

    always_comb begin
        go_resp = 1'b0;
        if (state_q == StIdle) begin
            go_resp = req && (WAIT_CYCLES == 0);
        end else if (state_q == StWait) begin
            go_resp = (cnt_q == LastCnt);
        end
    end

    assign mem_we = go_resp && cur_wr && !cur_bad && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= 32'd0;
            ctrl_q  <= DmWord;
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req) begin
                        wr_q    <= mem_w;
                        addr_q  <= Addr_in[AW+1:0];
                        data_q  <= Data_in;
                        ctrl_q  <= dm_ctrl;
                        cnt_q   <= 4'd0;
                        state_q <= (WAIT_CYCLES == 0) ? StResp : StWait;
                    end
                end
                StWait: begin
                    if (go_resp) begin
                        cnt_q   <= 4'd0;
                        state_q <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
            if (go_resp) begin
                ready_q <= 1'b1;
                err_q   <= cur_bad;
                if (!cur_wr && !cur_bad) begin
                    rdata_q <= mem[cur_idx];
                end
            end
        end
    end

    // Array deliberately has no reset: contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_mask[b]) begin
                    mem[cur_idx][8*b +: 8] <= cur_data[8*b +: 8];
                end
            end
        end
    end

    assign Data_out  = rdata_q;
    assign MIO_ready = ready_q;
`ifdef DMEM_MISALIGN_CHECK_EN
    assign err = err_q;
`else
    assign err = 1'b0;
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed accesses push expected responses, a monitor
// pops and checks data, err and latency on every MIO_ready strobe.
module tb_dmem_responder;

    localparam int unsigned WaitCycles = 1;

    logic        clk;
    logic        reset;
    logic        req;
    logic        mem_w;
    logic [31:0] Addr_in;
    logic [31:0] Data_in;
    logic [2:0]  dm_ctrl;
    logic [31:0] Data_out;
    logic        MIO_ready;
    logic        err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int cap_cyc = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        string       name;
    } exp_t;

    exp_t sb[$];

    dmem_responder #(
        .DEPTH_WORDS (1024),
        .WAIT_CYCLES (WaitCycles)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .mem_w     (mem_w),
        .Addr_in   (Addr_in),
        .Data_in   (Data_in),
        .dm_ctrl   (dm_ctrl),
        .Data_out  (Data_out),
        .MIO_ready (MIO_ready),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: every response strobe must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (MIO_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ready: got MIO_ready=1 expected no response");
                end else begin
                    e = sb.pop_front();
                    check32({e.name, "_data"}, Data_out, e.data);
                    check32({e.name, "_err"}, {31'd0, err}, {31'd0, e.err});
                    // Ready is sampled by the initiator on the edge after it rises.
                    check32({e.name, "_latency"}, 32'(cyc - cap_cyc + 1), 32'(WaitCycles + 1));
                end
            end else if (err !== 1'b0) begin
                total++;
                bad++;
                $display("FAIL stray_err: got err=%b expected 0", err);
            end
        end
    end

    task automatic access(input string name, input logic w, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] ctrl,
                          input logic [31:0] exp_data, input logic exp_err);
        bit seen;
        exp_t e;
        @(negedge clk);
        req     = 1'b1;
        mem_w   = w;
        Addr_in = addr;
        Data_in = wdata;
        dm_ctrl = ctrl;
        e.data = exp_data;
        e.err  = exp_err;
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1 cap_cyc = cyc;
        // Scramble inputs after capture; the transaction must be unaffected.
        Addr_in = 32'hFFFF_FFFF;
        Data_in = 32'h0BAD_0BAD;
        mem_w   = ~w;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (MIO_ready === 1'b1) seen = 1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no MIO_ready expected one within 20 cycles", name);
            void'(sb.pop_front());
        end
        req = 1'b0;
    endtask

    initial begin
        logic [31:0] misal_hold;
        logic [31:0] misal_mem;
        logic        misal_err;
`ifdef DMEM_MISALIGN_CHECK_EN
        misal_err  = 1'b1;
        misal_hold = 32'h5555_5555;
        misal_mem  = 32'h5555_5555;
`else
        misal_err  = 1'b0;
        misal_hold = 32'h5555_5555;
        misal_mem  = 32'hA5A5_A5A5;
`endif
        reset = 1'b1; req = 1'b0; mem_w = 1'b0;
        Addr_in = 32'd0; Data_in = 32'd0; dm_ctrl = 3'b000;
        repeat (3) @(negedge clk);
        check32("reset_data_out", Data_out, 32'd0);
        check32("reset_ready", {31'd0, MIO_ready}, 32'd0);
        check32("reset_err", {31'd0, err}, 32'd0);
        reset = 1'b0;

        access("wr_word_10", 1, 32'h10, 32'hDEAD_BEEF, 3'b000, 32'h0, 0);
        access("rd_word_10", 0, 32'h10, 32'h0, 3'b000, 32'hDEAD_BEEF, 0);
        access("rd_byte_13", 0, 32'h13, 32'h0, 3'b100, 32'hDEAD_BEEF, 0);

        access("wr_word_20", 1, 32'h20, 32'h0, 3'b000, 32'hDEAD_BEEF, 0);
        access("wr_byte_21", 1, 32'h21, 32'h0000_AB00, 3'b011, 32'hDEAD_BEEF, 0);
        access("rd_byte_20", 0, 32'h20, 32'h0, 3'b000, 32'h0000_AB00, 0);

        access("wr_ones_20", 1, 32'h20, 32'hFFFF_FFFF, 3'b000, 32'h0000_AB00, 0);
        access("wr_half_22", 1, 32'h22, 32'h1234_0000, 3'b001, 32'h0000_AB00, 0);
        access("rd_half_20", 0, 32'h20, 32'h0, 3'b000, 32'h1234_FFFF, 0);

        access("wr_wrap_1004", 1, 32'h1004, 32'hCAFE_F00D, 3'b000, 32'h1234_FFFF, 0);
        access("rd_wrap_0004", 0, 32'h0004, 32'h0, 3'b000, 32'hCAFE_F00D, 0);
        access("wr_hold_0008", 1, 32'h0008, 32'h1111_1111, 3'b000, 32'hCAFE_F00D, 0);
        access("rd_wrap_1008", 0, 32'h1008, 32'h0, 3'b000, 32'h1111_1111, 0);

        access("wr_prior_30", 1, 32'h30, 32'h5555_5555, 3'b000, 32'h1111_1111, 0);
        // Abort a write to 0x30 while it sits in WAIT.
        @(negedge clk);
        req = 1'b1; mem_w = 1'b1; Addr_in = 32'h30; Data_in = 32'h9999_9999; dm_ctrl = 3'b000;
        @(negedge clk);
        reset = 1'b1;
        req   = 1'b0;
        @(negedge clk);
        check32("abort_data_out", Data_out, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        access("rd_after_abort", 0, 32'h30, 32'h0, 3'b000, 32'h5555_5555, 0);

        access("wr_misal_31", 1, 32'h31, 32'hA5A5_A5A5, 3'b000, misal_hold, misal_err);
        access("rd_misal_30", 0, 32'h30, 32'h0, 3'b000, misal_mem, 0);

        repeat (4) @(negedge clk);
        check32("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish before 100us");
        $fatal(1);
    end

endmodule
